// File: rtl/gray_conv_pkg.sv
// Shared constants for the gray/binary streaming converter.
// Optional adjacency checking is enabled by defining GRAY_CONV_ADJ_CHECK_EN.
package gray_conv_pkg;
  localparam logic MODE_G2B   = 1'b0;
  localparam logic MODE_B2G   = 1'b1;
  localparam int   BEAT_CNT_W = 16;
endpackage

// File: rtl/gray_conv_core.sv
// Combinational gray<->binary converter. mode_i selects the direction.
module gray_conv_core
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             mode_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] bin;

  // Gray->binary is a prefix XOR from the MSB down; binary->gray is a shift-XOR.
  always_comb begin
    bin            = '0;
    bin[WIDTH-1]   = in_i[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) bin[i] = bin[i+1] ^ in_i[i];
    out_o = (mode_i == MODE_B2G) ? (in_i ^ (in_i >> 1)) : bin;
  end

endmodule

// File: rtl/gray_conv_stream.sv
// Streaming gray/binary converter: conversion ahead of a one-entry output
// register backed by a one-entry skid buffer (two beats in flight, in order).
// Define GRAY_CONV_ADJ_CHECK_EN to flag mode-0 inputs that are not one bit
// away from the previous mode-0 input; otherwise out_err is tied low.
module gray_conv_stream
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_mode,
  output logic                  out_err,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  logic [WIDTH-1:0] conv;
  logic             new_err;
  logic             accept, xfer;

  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q,  out_data_d;
  logic                  out_mode_q,  out_mode_d;
  logic                  out_err_q,   out_err_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0]      skid_data_q,  skid_data_d;
  logic                  skid_mode_q,  skid_mode_d;
  logic                  skid_err_q,   skid_err_d;
  logic                  in_ready_q;
  logic [BEAT_CNT_W-1:0] beat_cnt_q;

  gray_conv_core #(.WIDTH(WIDTH)) u_core (
    .mode_i (in_mode),
    .in_i   (in_data),
    .out_o  (conv)
  );

  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid_q && out_ready;

`ifdef GRAY_CONV_ADJ_CHECK_EN
  logic             hist_valid_q;
  logic [WIDTH-1:0] hist_q;

  assign new_err = hist_valid_q && (in_mode == MODE_G2B) &&
                   ($countones(in_data ^ hist_q) != 1);

  // Remember the last accepted mode-0 input word; mode-1 beats leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_valid_q <= 1'b0;
      hist_q       <= '0;
    end else if (accept && in_mode == MODE_G2B) begin
      hist_valid_q <= 1'b1;
      hist_q       <= in_data;
    end
  end
`else
  assign new_err = 1'b0;
`endif

  // Output/skid steering: skid drains into the output register on a transfer,
  // a new beat goes straight to the output register whenever it will be free.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_mode_d   = out_mode_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_mode_d  = skid_mode_q;
    skid_err_d   = skid_err_q;
    if (!out_valid_q || xfer) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_mode_d   = skid_mode_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = conv;
        out_mode_d  = in_mode;
        out_err_d   = new_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = conv;
      skid_mode_d  = in_mode;
      skid_err_d   = new_err;
    end
  end

  // State registers; in_ready is registered as "skid will be empty".
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_mode_q   <= 1'b0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_mode_q  <= 1'b0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_mode_q   <= out_mode_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_mode_q  <= skid_mode_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= !skid_valid_d;
      if (xfer) beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;
  assign out_err   = out_err_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_gray_conv_stream.sv
// Directed bench for gray_conv_stream at WIDTH=4.
module tb_gray_conv_stream;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_mode;
  logic [W-1:0] in_data;
  logic         out_valid, out_ready, out_mode, out_err;
  logic [W-1:0] out_data;
  logic [15:0]  beat_cnt;

  int nvec = 0;
  int nerr = 0;

  gray_conv_stream #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_err   (out_err),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] s_in  [4];
  logic [W-1:0] s_out [4];
  logic         s_err [4];

  initial begin
    s_in  = '{4'b0000, 4'b0001, 4'b0011, 4'b0000};
    s_out = '{4'b0000, 4'b0001, 4'b0010, 4'b0000};
`ifdef GRAY_CONV_ADJ_CHECK_EN
    s_err = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
    s_err = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset for two cycles
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_beat_cnt",  32'(beat_cnt),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    rst = 1'b0;
    tick();
    chk("rel_in_ready",  32'(in_ready),  32'd1);

    // Gray->binary: 1101 -> 1001
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 1'b0; in_data = 4'b1101;
    tick();
    in_valid = 1'b0;
    chk("g2b_valid", 32'(out_valid), 32'd1);
    chk("g2b_data",  32'(out_data),  32'b1001);
    chk("g2b_mode",  32'(out_mode),  32'd0);
    tick();
    chk("g2b_cnt",   32'(beat_cnt),  32'd1);

    // Binary->gray: 1011 -> 1110
    in_valid = 1'b1; in_mode = 1'b1; in_data = 4'b1011;
    tick();
    in_valid = 1'b0;
    chk("b2g_data",  32'(out_data),  32'b1110);
    chk("b2g_mode",  32'(out_mode),  32'd1);
    tick();
    chk("b2g_cnt",   32'(beat_cnt),  32'd2);

    // Backpressure: A=0011->0010, B=0110->0101, C=1000->1100 (mode 1)
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b1; in_data = 4'b0011;
    tick();
    chk("bp_a_data",  32'(out_data), 32'b0010);
    chk("bp_a_ready", 32'(in_ready), 32'd1);
    in_data = 4'b0110;
    tick();
    chk("bp_b_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_a",  32'(out_data), 32'b0010);
    in_data = 4'b1000;
    tick();
    chk("bp_hold_a2", 32'(out_data), 32'b0010);
    chk("bp_stall",   32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_b_data",  32'(out_data), 32'b0101);
    chk("bp_cnt3",    32'(beat_cnt), 32'd3);
    chk("bp_ready1",  32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_c_data",  32'(out_data), 32'b1100);
    chk("bp_c_valid", 32'(out_valid), 32'd1);
    chk("bp_cnt4",    32'(beat_cnt), 32'd4);
    tick();
    chk("bp_empty",   32'(out_valid), 32'd0);
    chk("bp_cnt5",    32'(beat_cnt), 32'd5);

    // Mid-operation reset discards in-flight beats
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_data = 4'b0101;
    tick(); tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_cnt",   32'(beat_cnt),  32'd0);
    chk("mrst_ready", 32'(in_ready),  32'd0);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("mrst_drain", 32'(out_valid), 32'd0);
    chk("mrst_cnt2",  32'(beat_cnt),  32'd0);

    // Adjacency stream, back-to-back
    in_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = s_in[i];
      tick();
      chk($sformatf("adj%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("adj%0d_data", i),  32'(out_data),  32'(s_out[i]));
      chk($sformatf("adj%0d_err", i),   32'(out_err),   32'(s_err[i]));
    end
    in_valid = 1'b0;
    tick();
    chk("adj_cnt", 32'(beat_cnt), 32'd4);

    // Counter wrap: 65536 transfers from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    in_valid = 1'b1; in_mode = 1'b1; in_data = 4'b0110;
    for (int k = 0; k < 65536; k++) tick();
    chk("wrap_ffff", 32'(beat_cnt), 32'hFFFF);
    chk("wrap_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("wrap_zero", 32'(beat_cnt), 32'd0);
    chk("wrap_empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
